// File: rtl/ifu_pkg.sv
// Shared encodings and helpers for the prefetching instruction fetch unit.
// Optional build macro used by the top level: IFU_PERF_EN.
package ifu_pkg;

    localparam int PC_W    = 32;
    localparam int EXC_W   = 5;
    localparam int ENTRY_W = PC_W + EXC_W;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_EXC  = 3'd4,
        NPC_ERET = 3'd5
    } npc_sel_e;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [EXC_W-1:0] exc;
    } fetch_entry_t;

    // A fetch address is only legal when word aligned and inside the text window.
    function automatic logic [EXC_W-1:0] excCode(input logic [PC_W-1:0] pc,
                                                 input logic [PC_W-1:0] base,
                                                 input logic [PC_W-1:0] limit);
        if (pc[1:0] != 2'b00 || pc < base || pc > limit)
            return EXC_ADEL;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched {PC, ExcCode} entries.
// Flush takes priority over push and pop in the same cycle.
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             doPush, doPop;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign count  = wrPtr_q - rdPtr_q;
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign rdata  = mem_q[rdPtr_q[AW-1:0]];
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + 1'b1;
            if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush)
            mem_q[wrPtr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch PC generator with redirect/flush, address-error halt and a prefetch queue.
// Define IFU_PERF_EN to add saturating redirect and queue-full performance counters.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter logic [31:0] TEXT_LIMIT = 32'h0000_6FFC,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     EN,
    input  logic [2:0]               nPC_sel,
    input  logic [31:0]              br_PC,
    input  logic [15:0]              sel_PC,
    input  logic [25:0]              instr_index,
    input  logic [31:0]              jr_PC,
    input  logic [31:0]              epc,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              PC,
    output logic [4:0]               ExcCode,
    output logic [$clog2(DEPTH):0]   count
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]              perf_redirects,
    output logic [31:0]              perf_full
`endif
);

    npc_sel_e     sel;
    logic [31:0]  fetchPc_q, fetchPc_d;
    logic         halt_q, halt_d;
    logic [31:0]  brBase, target;
    logic         redirect, push, pop, empty, full;
    logic [4:0]   newExc;
    fetch_entry_t pushEntry, headEntry;

    assign sel      = npc_sel_e'(nPC_sel);
    assign brBase   = br_PC + 32'd4;
    assign redirect = (nPC_sel >= 3'd1) && (nPC_sel <= 3'd5);
    assign newExc   = excCode(fetchPc_q, TEXT_BASE, TEXT_LIMIT);
    assign pop      = ~empty & out_ready;
    assign push     = ~redirect & EN & ~halt_q & (~full | pop);
    assign pushEntry = '{pc: fetchPc_q, exc: newExc};

    always_comb begin
        target = fetchPc_q;
        case (sel)
            NPC_BR:   target = brBase + {{14{sel_PC[15]}}, sel_PC, 2'b00};
            NPC_J:    target = {brBase[31:28], instr_index, 2'b00};
            NPC_JR:   target = jr_PC;
            NPC_EXC:  target = EXC_VECTOR;
            NPC_ERET: target = epc;
            default:  target = fetchPc_q;
        endcase
    end

    // An AdEL entry is the last one fetched until control flow is redirected.
    always_comb begin
        fetchPc_d = fetchPc_q;
        halt_d    = halt_q;
        if (redirect) begin
            fetchPc_d = target;
            halt_d    = 1'b0;
        end else if (push) begin
            fetchPc_d = fetchPc_q + 32'd4;
            halt_d    = (newExc == EXC_ADEL);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc_q <= RESET_PC;
            halt_q    <= 1'b0;
        end else begin
            fetchPc_q <= fetchPc_d;
            halt_q    <= halt_d;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (pushEntry),
        .rdata (headEntry),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign out_valid = ~empty;
    assign PC        = empty ? 32'd0 : headEntry.pc;
    assign ExcCode   = empty ? EXC_NONE : headEntry.exc;

`ifdef IFU_PERF_EN
    logic [31:0] perfRedirects_q, perfFull_q;
    logic        fullStall;

    assign fullStall = EN & ~redirect & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfRedirects_q <= '0;
            perfFull_q      <= '0;
        end else begin
            if (redirect && perfRedirects_q != 32'hFFFF_FFFF)
                perfRedirects_q <= perfRedirects_q + 32'd1;
            if (fullStall && perfFull_q != 32'hFFFF_FFFF)
                perfFull_q <= perfFull_q + 32'd1;
        end
    end

    assign perf_redirects = perfRedirects_q;
    assign perf_full      = perfFull_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a queue-based reference model predicts every
// entry the fetch unit should deliver, and a monitor checks each handshake against it.
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] TEXT_LIMIT = 32'h0000_6FFC;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam int          DEPTH      = 4;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  exc;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        EN;
    logic [2:0]  nPC_sel;
    logic [31:0] br_PC;
    logic [15:0] sel_PC;
    logic [25:0] instr_index;
    logic [31:0] jr_PC;
    logic [31:0] epc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] PC;
    logic [4:0]  ExcCode;
    logic [2:0]  count;
`ifdef IFU_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_full;
`endif

    int          checksTotal  = 0;
    int          checksPassed = 0;

    // Reference model state: what the unit should hold, independent of the RTL structure.
    expEntry_t   expQ[$];
    logic [31:0] mdlFetch;
    bit          mdlHalt;
    int          expCountNow;
    bit          expRedirect;
    bit          inReset;

    ifu_prefetch #(
        .RESET_PC   (RESET_PC),
        .TEXT_BASE  (TEXT_BASE),
        .TEXT_LIMIT (TEXT_LIMIT),
        .EXC_VECTOR (EXC_VECTOR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .EN          (EN),
        .nPC_sel     (nPC_sel),
        .br_PC       (br_PC),
        .sel_PC      (sel_PC),
        .instr_index (instr_index),
        .jr_PC       (jr_PC),
        .epc         (epc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .PC          (PC),
        .ExcCode     (ExcCode),
        .count       (count)
`ifdef IFU_PERF_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_full      (perf_full)
`endif
    );

    always #5 clk = ~clk;

    // Every comparison goes through here so the counters always stay in step.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checksTotal++;
        if (got === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    function automatic logic [4:0] mdlExc(input logic [31:0] pc);
        if ((pc % 4) != 0 || pc < TEXT_BASE || pc > TEXT_LIMIT) return 5'd4;
        return 5'd0;
    endfunction

    function automatic logic [31:0] mdlTarget(input logic [2:0] sel, input logic [31:0] br,
                                              input logic [15:0] off, input logic [25:0] idx,
                                              input logic [31:0] jr, input logic [31:0] ep);
        logic [31:0] nextSeq;
        nextSeq = br + 32'd4;
        case (sel)
            3'd1:    return nextSeq + 32'(int'($signed(off)) * 4);
            3'd2:    return (nextSeq & 32'hF000_0000) | (32'(idx) << 2);
            3'd3:    return jr;
            3'd4:    return EXC_VECTOR;
            default: return ep;
        endcase
    endfunction

    // Drives one cycle of inputs and advances the model to what the next edge should do.
    task automatic applyStimulus(input logic en, input logic ready, input logic [2:0] sel,
                                 input logic [31:0] br, input logic [15:0] off,
                                 input logic [25:0] idx, input logic [31:0] jr,
                                 input logic [31:0] ep);
        int  cnt;
        bit  popNow;
        logic [4:0] e;
        @(negedge clk);
        #2;
        EN = en; out_ready = ready; nPC_sel = sel;
        br_PC = br; sel_PC = off; instr_index = idx; jr_PC = jr; epc = ep;
        cnt = expQ.size();
        expCountNow = cnt;
        expRedirect = (sel >= 3'd1 && sel <= 3'd5);
        if (expRedirect) begin
            expQ.delete();
            mdlFetch = mdlTarget(sel, br, off, idx, jr, ep);
            mdlHalt  = 1'b0;
        end else begin
            popNow = (cnt > 0) && ready;
            if (en && !mdlHalt && (cnt < DEPTH || popNow)) begin
                e = mdlExc(mdlFetch);
                expQ.push_back('{pc: mdlFetch, exc: e});
                if (e != 5'd0) mdlHalt = 1'b1;
                mdlFetch = mdlFetch + 32'd4;
            end
        end
    endtask

    task automatic seqCycle(input logic en, input logic ready);
        applyStimulus(en, ready, 3'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0);
    endtask

    task automatic jumpReg(input logic ready, input logic [31:0] jr);
        applyStimulus(1'b1, ready, 3'd3, 32'd0, 16'd0, 26'd0, jr, 32'd0);
    endtask

    // Asserts reset between edges, checks the outputs collapse at once, then releases.
    task automatic doReset();
        @(negedge clk);
        #2;
        EN = 1'b0; out_ready = 1'b0; nPC_sel = 3'd0;
        reset   = 1'b0;
        inReset = 1'b1;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_PC", PC, 32'd0);
        checkOutput("reset_ExcCode", 32'(ExcCode), 32'd0);
`ifdef IFU_PERF_EN
        checkOutput("reset_perf_redirects", perf_redirects, 32'd0);
        checkOutput("reset_perf_full", perf_full, 32'd0);
`endif
        expQ.delete();
        mdlFetch    = RESET_PC;
        mdlHalt     = 1'b0;
        expCountNow = 0;
        expRedirect = 1'b0;
        @(negedge clk);
        #2;
        reset   = 1'b1;
        inReset = 1'b0;
    endtask

    // Monitor: checks occupancy every cycle and scores each accepted head entry.
    initial begin
        expEntry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!inReset) begin
                checkOutput("count", 32'(count), 32'(expCountNow));
                checkOutput("out_valid", 32'(out_valid), 32'(expCountNow != 0));
                if (!out_valid) begin
                    checkOutput("idle_PC", PC, 32'd0);
                    checkOutput("idle_ExcCode", 32'(ExcCode), 32'd0);
                end else if (out_ready && !expRedirect) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_entry", PC, 32'hDEAD_DEAD);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("head_PC", PC, e.pc);
                        checkOutput("head_ExcCode", 32'(ExcCode), 32'(e.exc));
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0]  rSel;
        logic [31:0] rJr, rEp, rBr;
        reset = 1'b0; inReset = 1'b1;
        EN = 1'b0; out_ready = 1'b0; nPC_sel = 3'd0;
        br_PC = '0; sel_PC = '0; instr_index = '0; jr_PC = '0; epc = '0;
        mdlFetch = RESET_PC; mdlHalt = 1'b0; expCountNow = 0; expRedirect = 1'b0;
        @(negedge clk);
        doReset();

        // Straight-line fetch with decode always ready.
        repeat (12) seqCycle(1'b1, 1'b1);

        // Back-pressure fills the queue, then it drains with no gaps.
        repeat (10) seqCycle(1'b1, 1'b0);
        repeat (8)  seqCycle(1'b1, 1'b1);

        // JR redirect mid-stream.
        jumpReg(1'b1, 32'h0000_305C);
        repeat (4) seqCycle(1'b1, 1'b1);

        // Misaligned target halts fetch until the exception vector redirect.
        jumpReg(1'b1, 32'h0000_3062);
        repeat (5) seqCycle(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'd4, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        repeat (5) seqCycle(1'b1, 1'b1);

        // Backward branch, then a branch on a full queue with decode ready.
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h0000_3020, 16'hFFFC, 26'd0, 32'd0, 32'd0);
        repeat (4) seqCycle(1'b1, 1'b1);
        repeat (6) seqCycle(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h0000_3020, 16'hFFFC, 26'd0, 32'd0, 32'd0);
        repeat (4) seqCycle(1'b1, 1'b1);

        // J target while fetch is disabled, then resume.
        applyStimulus(1'b0, 1'b1, 3'd2, 32'h0000_3100, 16'd0, 26'h00_1400, 32'd0, 32'd0);
        repeat (2) seqCycle(1'b0, 1'b1);
        repeat (3) seqCycle(1'b1, 1'b1);

        // Top of the text window, and ERET below its base.
        jumpReg(1'b1, 32'h0000_6FF8);
        repeat (5) seqCycle(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'd5, 32'd0, 16'd0, 26'd0, 32'd0, 32'h0000_2FFC);
        repeat (3) seqCycle(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'd5, 32'd0, 16'd0, 26'd0, 32'd0, 32'h0000_3400);
        repeat (3) seqCycle(1'b1, 1'b0);

        // Asynchronous reset in the middle of a stream.
        doReset();
        repeat (5) seqCycle(1'b1, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rSel = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(1, 7));
            rBr  = TEXT_BASE + (32'($urandom_range(0, 32'h0FFF)) << 2);
            rJr  = ($urandom_range(0, 7) == 0) ? $urandom()
                                               : TEXT_BASE + (32'($urandom_range(0, 32'h0FFF)) << 2);
            rEp  = ($urandom_range(0, 7) == 0) ? $urandom()
                                               : TEXT_BASE + (32'($urandom_range(0, 32'h0FFF)) << 2);
            if ($urandom_range(0, 199) == 0)
                doReset();
            else
                applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7), rSel,
                              rBr, 16'($urandom()), 26'($urandom()), rJr, rEp);
        end

        repeat (8) seqCycle(1'b0, 1'b1);
        @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
